// File: rtl/gpio_port_arbiter.sv
// gpio_port_arbiter
//   Two-port round-robin arbiter in front of the single GPIO register port.
//   Port 0 is the APB host path, port 1 the on-chip sequencer. One access is
//   in flight at a time; hung accesses are aborted after TIMEOUT cycles.
//   Optional feature macro: GPIO_ARB_LOCK_EN (locked multi-access sequences).
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | no transaction; arbitrate and accept a command (req_ready pulse)
//   ACCESS | drive wr_en/rd_en with latched addr/wdata/strb, wait gpio_ready
//   RESP   | hold rsp_valid to the owner until it handshakes rsp_ready

module gpio_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                        PCLK,
    input  logic                        PRESET,
    input  logic [1:0]                  req_valid,
    output logic [1:0]                  req_ready,
    input  logic [1:0]                  req_we,
    input  logic [2*ADDR_WIDTH-1:0]     req_addr,
    input  logic [2*DATA_WIDTH-1:0]     req_wdata,
    input  logic [2*DATA_WIDTH/8-1:0]   req_strb,
    input  logic [1:0]                  req_lock,
    output logic [1:0]                  rsp_valid,
    input  logic [1:0]                  rsp_ready,
    output logic [DATA_WIDTH-1:0]       rsp_rdata,
    output logic                        rsp_error,
    output logic                        gpio_wr_en,
    output logic                        gpio_rd_en,
    output logic [ADDR_WIDTH-1:0]       gpio_reg_addr,
    output logic [DATA_WIDTH-1:0]       gpio_wdata,
    output logic [DATA_WIDTH/8-1:0]     gpio_strb,
    input  logic [DATA_WIDTH-1:0]       gpio_rdata,
    input  logic                        gpio_ready,
    input  logic                        gpio_error
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    owner_q;
    logic                    last_grant_q;
    logic [CW-1:0]           cnt_q;
    logic                    gpio_wr_en_q;
    logic                    gpio_rd_en_q;
    logic [ADDR_WIDTH-1:0]   gpio_addr_q;
    logic [DATA_WIDTH-1:0]   gpio_wdata_q;
    logic [SW-1:0]           gpio_strb_q;
    logic [1:0]              rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_error_q;

    logic [1:0]              eligible;
    logic                    win;
    logic                    grant_valid;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [SW-1:0]           sel_strb;

`ifdef GPIO_ARB_LOCK_EN
    logic                    lock_q;
    logic                    cur_lock_q;

    // While locked, only the lock holder may be granted.
    always_comb begin
        eligible = req_valid;
        if (lock_q) begin
            eligible = req_valid & (owner_q ? 2'b10 : 2'b01);
        end
    end
`else
    logic                    lock_unused;
    assign lock_unused = ^req_lock;

    // Without locking every valid request is eligible.
    always_comb begin
        eligible = req_valid;
    end
`endif

    // Round-robin pick: on contention the port that did not win last time goes.
    always_comb begin
        win         = (&eligible) ? ~last_grant_q : eligible[1];
        grant_valid = (state_q == IDLE) && (|eligible);
        req_ready   = 2'b00;
        if (grant_valid) begin
            req_ready = win ? 2'b10 : 2'b01;
        end
        sel_addr  = win ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
        sel_wdata = win ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
        sel_strb  = win ? req_strb[2*SW-1:SW] : req_strb[SW-1:0];
    end

    // Transaction FSM with registered GPIO strobes and response outputs.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            gpio_wr_en_q <= 1'b0;
            gpio_rd_en_q <= 1'b0;
            gpio_addr_q  <= '0;
            gpio_wdata_q <= '0;
            gpio_strb_q  <= '0;
            rsp_valid_q  <= 2'b00;
            rsp_rdata_q  <= '0;
            rsp_error_q  <= 1'b0;
`ifdef GPIO_ARB_LOCK_EN
            lock_q       <= 1'b0;
            cur_lock_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        owner_q      <= win;
                        gpio_wr_en_q <= req_we[win];
                        gpio_rd_en_q <= ~req_we[win];
                        gpio_addr_q  <= sel_addr;
                        gpio_wdata_q <= sel_wdata;
                        gpio_strb_q  <= sel_strb;
                        cnt_q        <= CNT_LOAD;
                        state_q      <= ACCESS;
`ifdef GPIO_ARB_LOCK_EN
                        cur_lock_q   <= req_lock[win];
                        lock_q       <= lock_q | req_lock[win];
`endif
                    end
                end
                ACCESS: begin
                    if (gpio_ready) begin
                        rsp_rdata_q  <= gpio_wr_en_q ? '0 : gpio_rdata;
                        rsp_error_q  <= gpio_error;
                        gpio_wr_en_q <= 1'b0;
                        gpio_rd_en_q <= 1'b0;
                        rsp_valid_q  <= owner_q ? 2'b10 : 2'b01;
                        state_q      <= RESP;
                    end else if (cnt_q == '0) begin
                        rsp_rdata_q  <= '0;
                        rsp_error_q  <= 1'b1;
                        gpio_wr_en_q <= 1'b0;
                        gpio_rd_en_q <= 1'b0;
                        rsp_valid_q  <= owner_q ? 2'b10 : 2'b01;
                        state_q      <= RESP;
`ifdef GPIO_ARB_LOCK_EN
                        // A hung access must not leave the other port starved.
                        lock_q       <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready[owner_q]) begin
                        rsp_valid_q  <= 2'b00;
                        rsp_rdata_q  <= '0;
                        rsp_error_q  <= 1'b0;
                        cnt_q        <= '0;
                        last_grant_q <= owner_q;
                        state_q      <= IDLE;
`ifdef GPIO_ARB_LOCK_EN
                        if (!cur_lock_q) begin
                            lock_q <= 1'b0;
                        end
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_error     = rsp_error_q;
    assign gpio_wr_en    = gpio_wr_en_q;
    assign gpio_rd_en    = gpio_rd_en_q;
    assign gpio_reg_addr = gpio_addr_q;
    assign gpio_wdata    = gpio_wdata_q;
    assign gpio_strb     = gpio_strb_q;

endmodule
